palindrome_stream_checker: RTL and testbench

PALINDROME_STREAM_CHECKER -- requirements
Module: palindrome_stream_checker

---
 rtl/palindrome_pkg.sv | 13 +
 rtl/palin_sym_buf.sv | 31 +++
 rtl/palindrome_stream_checker.sv | 148 ++++++++++++++
 tb/tb_palindrome_stream_checker.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/palindrome_pkg.sv
// Shared FSM state type and default sizing for the palindrome stream checker.
package palindrome_pkg;

  localparam int unsigned SYM_W_DEF   = 8;
  localparam int unsigned MAX_LEN_DEF = 16;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CHECK   = 2'd1,
    RESULT  = 2'd2
  } state_t;

endpackage

// File: rtl/palin_sym_buf.sv
// Frame symbol store: one synchronous write port, two combinational read ports.
module palin_sym_buf
  import palindrome_pkg::*;
#(
  parameter int unsigned SYM_W = SYM_W_DEF,
  parameter int unsigned DEPTH = MAX_LEN_DEF,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [SYM_W-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr_a,
  output logic [SYM_W-1:0] o_rdata_a,
  input  logic [AW-1:0]    i_raddr_b,
  output logic [SYM_W-1:0] o_rdata_b
);

  logic [SYM_W-1:0] r_mem [DEPTH];

  // Contents are never reset; only indices below the stored length are read.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/palindrome_stream_checker.sv
// Collects a framed symbol stream, then checks it pairwise for palindrome symmetry.
// Define PALIN_EARLY_EXIT_EN to end the check on the first mismatching pair.
module palindrome_stream_checker
  import palindrome_pkg::*;
#(
  parameter int unsigned SYM_W   = SYM_W_DEF,
  parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [SYM_W-1:0]             s_data,
  input  logic                         s_last,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         res_palin,
  output logic [$clog2(MAX_LEN+1)-1:0] res_len,
  output logic                         res_ovf
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = $clog2(MAX_LEN);
  localparam logic [LW-1:0] MAX_CNT = LW'(MAX_LEN);

  state_t          r_state;
  logic [LW-1:0]   r_cnt;
  logic [LW-1:0]   r_k;
  logic            r_ovf;
  logic            r_mis;
  logic            r_s_ready;
  logic            r_res_valid;
  logic            r_res_palin;
  logic [LW-1:0]   r_res_len;
  logic            r_res_ovf;

  logic             w_xfer;
  logic             w_we;
  logic [LW-1:0]    w_half;
  logic [LW-1:0]    w_npairs;
  logic             w_cmp_en;
  logic             w_done;
  logic [AW-1:0]    w_waddr;
  logic [AW-1:0]    w_raddr_a;
  logic [AW-1:0]    w_raddr_b;
  logic [SYM_W-1:0] w_rdata_a;
  logic [SYM_W-1:0] w_rdata_b;

  palin_sym_buf #(
    .SYM_W (SYM_W),
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (s_data),
    .i_raddr_a (w_raddr_a),
    .o_rdata_a (w_rdata_a),
    .i_raddr_b (w_raddr_b),
    .o_rdata_b (w_rdata_b)
  );

  // A CHECK pass takes npairs compare steps plus one step that latches the result;
  // overflowed and single-symbol frames still take one (empty) compare step.
  always_comb begin
    w_xfer    = s_valid && r_s_ready;
    w_we      = w_xfer && (r_state == COLLECT) && (r_cnt != MAX_CNT);
    w_half    = r_cnt >> 1;
    w_npairs  = (r_ovf || (w_half == '0)) ? LW'(1) : w_half;
    w_cmp_en  = !r_ovf && (r_k < w_half);
    w_waddr   = AW'(r_cnt);
    w_raddr_a = AW'(r_k);
    w_raddr_b = AW'(r_cnt - r_k - LW'(1));
`ifdef PALIN_EARLY_EXIT_EN
    w_done    = (r_k == w_npairs) || r_mis;
`else
    w_done    = (r_k == w_npairs);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= COLLECT;
      r_cnt       <= '0;
      r_k         <= '0;
      r_ovf       <= 1'b0;
      r_mis       <= 1'b0;
      r_s_ready   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_palin <= 1'b0;
      r_res_len   <= '0;
      r_res_ovf   <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          r_s_ready <= 1'b1;
          if (w_xfer) begin
            if (r_cnt != MAX_CNT) begin
              r_cnt <= r_cnt + LW'(1);
            end else begin
              r_ovf <= 1'b1;
            end
            if (s_last) begin
              r_state   <= CHECK;
              r_s_ready <= 1'b0;
              r_k       <= '0;
              r_mis     <= 1'b0;
            end
          end
        end
        CHECK: begin
          if (w_done) begin
            r_state     <= RESULT;
            r_res_valid <= 1'b1;
            r_res_palin <= !r_ovf && !r_mis;
            r_res_len   <= r_cnt;
            r_res_ovf   <= r_ovf;
          end else begin
            if (w_cmp_en && (w_rdata_a != w_rdata_b)) begin
              r_mis <= 1'b1;
            end
            r_k <= r_k + LW'(1);
          end
        end
        RESULT: begin
          if (res_ready) begin
            r_state     <= COLLECT;
            r_res_valid <= 1'b0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_s_ready   <= 1'b1;
          end
        end
        default: begin
          r_state <= COLLECT;
        end
      endcase
    end
  end

  assign s_ready   = r_s_ready;
  assign res_valid = r_res_valid;
  assign res_palin = r_res_palin;
  assign res_len   = r_res_len;
  assign res_ovf   = r_res_ovf;

endmodule

// File: tb/tb_palindrome_stream_checker.sv
// Scoreboard bench for palindrome_stream_checker (build with or without PALIN_EARLY_EXIT_EN).
module tb_palindrome_stream_checker;

  localparam int unsigned SYM_W   = 8;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned LW      = $clog2(MAX_LEN + 1);

  typedef struct {
    logic palin;
    int   len;
    logic ovf;
    int   lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [SYM_W-1:0] s_data = '0;
  logic             s_last = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic             res_palin;
  logic [LW-1:0]    res_len;
  logic             res_ovf;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_edge = 0;
  logic [7:0]  fbuf [0:31];
  exp_t        sb [$];

  palindrome_stream_checker #(
    .SYM_W   (SYM_W),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_palin (res_palin),
    .res_len   (res_len),
    .res_ovf   (res_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives fbuf[0..n-1] as one frame; optionally pushes the modelled result.
  task automatic send_frame(input int n, input bit push);
    exp_t e;
    int   stored;
    int   mis_at;
    int   t;
    stored = (n > MAX_LEN) ? MAX_LEN : n;
    e.ovf  = (n > MAX_LEN);
    e.len  = stored;
    e.palin = 1'b1;
    mis_at = -1;
    for (int k = 0; k < stored / 2; k++) begin
      if (fbuf[k] != fbuf[stored-1-k]) begin
        e.palin = 1'b0;
        if (mis_at < 0) mis_at = k;
      end
    end
    if (e.ovf) e.palin = 1'b0;
    e.lat = e.ovf ? 2 : (((stored / 2) > 1 ? (stored / 2) : 1) + 1);
`ifdef PALIN_EARLY_EXIT_EN
    if (!e.ovf && mis_at >= 0) e.lat = mis_at + 2;
`endif
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = fbuf[i];
      s_last  = (i == n - 1);
      t = 0;
      while (!s_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!s_ready) begin
        check_eq("xfer_timeout", 32'd0, 32'd1);
        break;
      end
      if (i == n - 1) last_edge = cyc + 1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (push) sb.push_back(e);
  endtask

  // Waits for a result, holds it for 'hold' cycles, then compares and handshakes.
  task automatic get_result(input int hold);
    exp_t          e;
    int            n;
    bit            rdy_ok;
    bit            stab_ok;
    logic          p0;
    logic          o0;
    logic [LW-1:0] l0;
    n = 0;
    rdy_ok = 1'b1;
    stab_ok = 1'b1;
    while (!res_valid && n < 100) begin
      rdy_ok = rdy_ok & !s_ready;
      @(negedge clk);
      n++;
    end
    if (!res_valid) begin
      check_eq("res_timeout", 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check_eq("latency", cyc - last_edge, e.lat);
    p0 = res_palin;
    o0 = res_ovf;
    l0 = res_len;
    for (int h = 0; h < hold; h++) begin
      rdy_ok  = rdy_ok & !s_ready;
      stab_ok = stab_ok & res_valid & (res_palin == p0) & (res_ovf == o0) & (res_len == l0);
      @(negedge clk);
    end
    if (hold > 0) check_eq("hold_stable", stab_ok, 32'd1);
    rdy_ok = rdy_ok & !s_ready;
    check_eq("s_ready_low", rdy_ok, 32'd1);
    check_eq("res_palin", res_palin, e.palin);
    check_eq("res_len", res_len, e.len);
    check_eq("res_ovf", res_ovf, e.ovf);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_eq("valid_drop", res_valid, 32'd0);
    check_eq("s_ready_back", s_ready, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_s_ready"}, s_ready, 32'd0);
    check_eq({tag, "_res_valid"}, res_valid, 32'd0);
    check_eq({tag, "_res_palin"}, res_palin, 32'd0);
    check_eq({tag, "_res_len"}, res_len, 32'd0);
    check_eq({tag, "_res_ovf"}, res_ovf, 32'd0);
  endtask

  initial begin
    int len;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    #1;
    check_eq("s_ready_pre_edge", s_ready, 32'd0);
    @(negedge clk);
    check_eq("s_ready_post_rst", s_ready, 32'd1);

    fbuf[0] = 8'h12; fbuf[1] = 8'h34; fbuf[2] = 8'h12;
    send_frame(3, 1'b1);
    get_result(0);

    fbuf[0] = 8'hA1; fbuf[1] = 8'hB2; fbuf[2] = 8'hB2; fbuf[3] = 8'hA0;
    send_frame(4, 1'b1);
    get_result(0);

    fbuf[0] = 8'h5A;
    send_frame(1, 1'b1);
    get_result(0);

    // Stored part is symmetric, so only overflow can clear res_palin.
    for (int i = 0; i < 20; i++) fbuf[i] = 8'((i < 8) ? i : ((i < 16) ? 15 - i : 8'hEE));
    send_frame(20, 1'b1);
    get_result(1);

    for (int i = 0; i < 8; i++) fbuf[i] = 8'((i < 4) ? 8'h30 + i : 8'h37 - i);
    send_frame(8, 1'b1);
    get_result(5);

    fbuf[0] = 8'h01; fbuf[1] = 8'h02; fbuf[2] = 8'h03; fbuf[3] = 8'h04;
    fbuf[4] = 8'h09; fbuf[5] = 8'h02; fbuf[6] = 8'h01;
    send_frame(7, 1'b1);
    get_result(2);

    for (int i = 0; i < 16; i++) fbuf[i] = 8'((i < 8) ? 8'h80 + i : 8'h8F - i);
    send_frame(16, 1'b1);
    get_result(0);

    // Reset while the checker is mid-CHECK; that frame's result is abandoned.
    for (int i = 0; i < 8; i++) fbuf[i] = 8'h11;
    send_frame(8, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("s_ready_after_midrst", s_ready, 32'd1);
    fbuf[0] = 8'h07; fbuf[1] = 8'h07;
    send_frame(2, 1'b1);
    get_result(0);

    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) fbuf[i] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < len / 2; i++) fbuf[len-1-i] = fbuf[i];
      end
      send_frame(len, 1'b1);
      get_result($urandom_range(0, 3));
    end

    check_eq("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
